// File: rtl/mips32_pkg.sv
// Shared constants and helpers for the mips32 bus-side blocks.
package mips32_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Channel-index width; a single channel still gets a 1-bit index.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request picker: fixed priority (lowest index) or
// round-robin search starting at rr_ptr and wrapping N-1 -> 0.
module rr_arbiter
    import mips32_pkg::*;
#(
    parameter int N    = 3,
    parameter int MODE = MODE_FIXED,
    parameter int SELW = sel_width(N)   // derived, leave at default
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] rr_ptr,
    output logic [SELW-1:0] grant_idx,
    output logic            any_req
);

    int   idx;
    logic found;

    // Walk the N candidates in policy order and keep the first requester.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (MODE == MODE_RR) ? int'(rr_ptr) + k : k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = SELW'(idx);
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/mux_arb.sv
// N-input arbitrated multiplexer with valid/ready handshake, burst lock
// and a single registered output stage (1 beat/cycle sustained).
module mux_arb
    import mips32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 3,
    parameter int MODE  = MODE_FIXED,
    parameter int SELW  = sel_width(N)  // derived, leave at default
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready
);

    logic             locked;
    logic [SELW-1:0]  lock_idx;
    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  arb_grant;
    logic [SELW-1:0]  grant;
    logic             any_valid;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             sel_last;
    logic             sel_valid;

    rr_arbiter #(
        .N    (N),
        .MODE (MODE),
        .SELW (SELW)
    ) u_arb (
        .req       (in_valid),
        .rr_ptr    (rr_ptr),
        .grant_idx (arb_grant),
        .any_req   (any_valid)
    );

    // Grant resolution and the granted channel's beat; a held lock overrides the arbiter.
    always_comb begin
        grant     = locked ? lock_idx : arb_grant;
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                sel_data  = in_data[i*WIDTH +: WIDTH];
                sel_last  = in_last[i];
                sel_valid = in_valid[i];
            end
        end
    end

    // Accept only while reset is released so producers see no ready during reset.
    always_comb begin
        can_load = reset_n && (!out_valid || out_ready);
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = can_load && any_valid && (grant == SELW'(i));
        end
        xfer = can_load && any_valid && sel_valid;
    end

    // Output register, burst lock and round-robin pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            locked    <= 1'b0;
            lock_idx  <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant;
            out_last  <= sel_last;
            locked    <= !sel_last;
            lock_idx  <= grant;
            if (sel_last) begin
                rr_ptr <= (grant == SELW'(N-1)) ? '0 : grant + SELW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
